// File: rtl/immu_fetch_resp.sv
// Fetch-side MMU responder: translates pc, issues 8-byte reads,
// and returns one or two instruction words per accepted request.
module immu_fetch_resp #(
   parameter int DEPTH = 4
) (
   input  logic        clk,
   input  logic        resetn,
   input  logic        mmu_i_req,
   input  logic [31:0] mmu_i_addr,
   output logic        mmu_i_addr_ok,
   output logic        mmu_i_double,
   output logic        mmu_i_data_ok,
   output logic [63:0] mmu_i_rdata,
   output logic        mmu_i_tlbr,
   output logic        mmu_i_pif,
   output logic        mmu_i_ppi,
   input  logic        csr_da,
   input  logic [1:0]  csr_plv,
   input  logic [2:0]  dmw0_vseg,
   input  logic [2:0]  dmw0_pseg,
   input  logic        dmw0_plv0,
   input  logic        dmw0_plv3,
   input  logic [2:0]  dmw1_vseg,
   input  logic [2:0]  dmw1_pseg,
   input  logic        dmw1_plv0,
   input  logic        dmw1_plv3,
   output logic [31:0] tlb_vaddr,
   input  logic        tlb_found,
   input  logic        tlb_v,
   input  logic [1:0]  tlb_plv,
   input  logic [19:0] tlb_ppn,
   output logic        mem_req,
   output logic [31:0] mem_addr,
   input  logic        mem_addr_ok,
   input  logic        mem_data_ok,
   input  logic [63:0] mem_rdata
);

   localparam int CW = $clog2(DEPTH + 1);
   localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   logic [DEPTH-1:0] r_sel;
   logic [PW-1:0]    r_wp;
   logic [PW-1:0]    r_rp;
   logic [CW-1:0]    r_cnt;

   logic        w_dmw0_hit;
   logic        w_dmw1_hit;
   logic        w_tlb_path;
   logic [31:0] w_pa;
   logic        w_excp;
   logic        w_push;
   logic        w_pop;
   logic        w_head;

   assign w_dmw0_hit = (mmu_i_addr[31:29] == dmw0_vseg) &&
                       ((csr_plv == 2'd0 && dmw0_plv0) ||
                        (csr_plv == 2'd3 && dmw0_plv3));
   assign w_dmw1_hit = (mmu_i_addr[31:29] == dmw1_vseg) &&
                       ((csr_plv == 2'd0 && dmw1_plv0) ||
                        (csr_plv == 2'd3 && dmw1_plv3));
   assign w_tlb_path = !csr_da && !w_dmw0_hit && !w_dmw1_hit;

   always_comb begin
      w_pa = mmu_i_addr;
      unique case (1'b1)
         csr_da:     w_pa = mmu_i_addr;
         w_dmw0_hit: w_pa = {dmw0_pseg, mmu_i_addr[28:0]};
         w_dmw1_hit: w_pa = {dmw1_pseg, mmu_i_addr[28:0]};
         default:    w_pa = {tlb_ppn, mmu_i_addr[11:0]};
      endcase
   end

   assign mmu_i_tlbr = w_tlb_path && !tlb_found;
   assign mmu_i_pif  = w_tlb_path && tlb_found && !tlb_v;
   assign mmu_i_ppi  = w_tlb_path && tlb_found && tlb_v &&
                       (csr_plv > tlb_plv);
   assign w_excp     = mmu_i_tlbr | mmu_i_pif | mmu_i_ppi;

   assign tlb_vaddr    = mmu_i_addr;
   assign mmu_i_double = !mmu_i_addr[2];

   // A pop in the same cycle frees a slot, so a full FIFO can still accept.
   assign w_pop   = resetn && mem_data_ok && (r_cnt != '0);
   assign mem_req = resetn && mmu_i_req && !w_excp &&
                    ((r_cnt < CW'(DEPTH)) || w_pop);
   assign mem_addr      = w_pa & ~32'h7;
   assign mmu_i_addr_ok = mem_req && mem_addr_ok;
   assign w_push        = mmu_i_addr_ok;

   assign w_head        = r_sel[r_rp];
   assign mmu_i_data_ok = w_pop;
   assign mmu_i_rdata   = w_head ? {32'h0, mem_rdata[63:32]} : mem_rdata;

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         r_sel <= '0;
         r_wp  <= '0;
         r_rp  <= '0;
         r_cnt <= '0;
      end else begin
         if (w_push) begin
            r_sel[r_wp] <= mmu_i_addr[2];
            r_wp <= (r_wp == PW'(DEPTH - 1)) ? '0 : r_wp + 1'b1;
         end
         if (w_pop)
            r_rp <= (r_rp == PW'(DEPTH - 1)) ? '0 : r_rp + 1'b1;
         if (w_push && !w_pop)
            r_cnt <= r_cnt + 1'b1;
         else if (w_pop && !w_push)
            r_cnt <= r_cnt - 1'b1;
      end
   end

endmodule

// File: tb/tb_immu_fetch_resp.sv
// Directed bench for immu_fetch_resp: translation, flags,
// FIFO fill/drain ordering, and reset mid-operation.
module tb_immu_fetch_resp;

   logic        clk = 1'b0;
   logic        resetn;
   logic        mmu_i_req;
   logic [31:0] mmu_i_addr;
   logic        mmu_i_addr_ok;
   logic        mmu_i_double;
   logic        mmu_i_data_ok;
   logic [63:0] mmu_i_rdata;
   logic        mmu_i_tlbr;
   logic        mmu_i_pif;
   logic        mmu_i_ppi;
   logic        csr_da;
   logic [1:0]  csr_plv;
   logic [2:0]  dmw0_vseg, dmw0_pseg, dmw1_vseg, dmw1_pseg;
   logic        dmw0_plv0, dmw0_plv3, dmw1_plv0, dmw1_plv3;
   logic [31:0] tlb_vaddr;
   logic        tlb_found, tlb_v;
   logic [1:0]  tlb_plv;
   logic [19:0] tlb_ppn;
   logic        mem_req;
   logic [31:0] mem_addr;
   logic        mem_addr_ok;
   logic        mem_data_ok;
   logic [63:0] mem_rdata;

   int n_vec = 0;
   int n_err = 0;

   always #5 clk = ~clk;

   immu_fetch_resp #(.DEPTH(4)) dut (
      .clk(clk), .resetn(resetn),
      .mmu_i_req(mmu_i_req), .mmu_i_addr(mmu_i_addr),
      .mmu_i_addr_ok(mmu_i_addr_ok), .mmu_i_double(mmu_i_double),
      .mmu_i_data_ok(mmu_i_data_ok), .mmu_i_rdata(mmu_i_rdata),
      .mmu_i_tlbr(mmu_i_tlbr), .mmu_i_pif(mmu_i_pif),
      .mmu_i_ppi(mmu_i_ppi),
      .csr_da(csr_da), .csr_plv(csr_plv),
      .dmw0_vseg(dmw0_vseg), .dmw0_pseg(dmw0_pseg),
      .dmw0_plv0(dmw0_plv0), .dmw0_plv3(dmw0_plv3),
      .dmw1_vseg(dmw1_vseg), .dmw1_pseg(dmw1_pseg),
      .dmw1_plv0(dmw1_plv0), .dmw1_plv3(dmw1_plv3),
      .tlb_vaddr(tlb_vaddr), .tlb_found(tlb_found),
      .tlb_v(tlb_v), .tlb_plv(tlb_plv), .tlb_ppn(tlb_ppn),
      .mem_req(mem_req), .mem_addr(mem_addr),
      .mem_addr_ok(mem_addr_ok), .mem_data_ok(mem_data_ok),
      .mem_rdata(mem_rdata)
   );

   task automatic chk(input string tag, input logic [63:0] got,
                      input logic [63:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic step();
      @(negedge clk);
      mmu_i_req   = 1'b0;
      mem_data_ok = 1'b0;
   endtask

   initial begin
      int acc;
      logic [63:0] d;
      resetn = 1'b0; mmu_i_req = 1'b0; mmu_i_addr = '0;
      csr_da = 1'b1; csr_plv = 2'd0;
      dmw0_vseg = 3'd0; dmw0_pseg = 3'd0; dmw0_plv0 = 1'b0; dmw0_plv3 = 1'b0;
      dmw1_vseg = 3'd0; dmw1_pseg = 3'd0; dmw1_plv0 = 1'b0; dmw1_plv3 = 1'b0;
      tlb_found = 1'b0; tlb_v = 1'b0; tlb_plv = 2'd0; tlb_ppn = '0;
      mem_addr_ok = 1'b1; mem_data_ok = 1'b0; mem_rdata = '0;
      #1;
      mmu_i_req = 1'b1; mem_data_ok = 1'b1;
      #1;
      chk("rst_mem_req", mem_req, 0);
      chk("rst_data_ok", mmu_i_data_ok, 0);
      step();
      resetn = 1'b1;

      // direct mode
      step();
      mmu_i_req = 1'b1; mmu_i_addr = 32'h1c00_0000;
      #1;
      chk("da_addr_ok", mmu_i_addr_ok, 1);
      chk("da_mem_addr", mem_addr, 64'h1c00_0000);
      chk("da_double", mmu_i_double, 1);
      chk("da_flags", {mmu_i_tlbr, mmu_i_pif, mmu_i_ppi}, 0);
      step();
      mem_data_ok = 1'b1; mem_rdata = 64'h1111_2222_3333_4444;
      #1;
      chk("da_data_ok", mmu_i_data_ok, 1);
      chk("da_rdata", mmu_i_rdata, 64'h1111_2222_3333_4444);

      // DMW0 window, odd word
      step();
      csr_da = 1'b0; dmw0_vseg = 3'd4; dmw0_plv0 = 1'b1;
      mmu_i_req = 1'b1; mmu_i_addr = 32'h9c00_0004;
      #1;
      chk("dmw0_addr_ok", mmu_i_addr_ok, 1);
      chk("dmw0_mem_addr", mem_addr, 64'h1c00_0000);
      chk("dmw0_double", mmu_i_double, 0);
      step();
      mem_data_ok = 1'b1;
      #1;
      chk("dmw0_data_ok", mmu_i_data_ok, 1);
      chk("dmw0_rdata", mmu_i_rdata, 64'h0000_0000_1111_2222);

      // DMW1 at plv3; DMW0 does not match plv3
      step();
      csr_plv = 2'd3; dmw1_vseg = 3'd5; dmw1_pseg = 3'd1; dmw1_plv3 = 1'b1;
      mmu_i_req = 1'b1; mmu_i_addr = 32'ha000_1008;
      #1;
      chk("dmw1_mem_addr", mem_addr, 64'h2000_1008);
      chk("dmw1_addr_ok", mmu_i_addr_ok, 1);
      step();
      mem_data_ok = 1'b1;
      #1;
      chk("dmw1_rdata", mmu_i_rdata, 64'h1111_2222_3333_4444);

      // TLB exceptions
      step();
      csr_plv = 2'd0; dmw0_plv0 = 1'b0; dmw1_plv3 = 1'b0;
      mmu_i_req = 1'b1; mmu_i_addr = 32'h0040_0abc;
      #1;
      chk("tlbr_flag", mmu_i_tlbr, 1);
      chk("tlbr_mem_req", mem_req, 0);
      chk("tlbr_addr_ok", mmu_i_addr_ok, 0);
      tlb_found = 1'b1;
      #1;
      chk("pif_flags", {mmu_i_tlbr, mmu_i_pif, mmu_i_ppi}, 3'b010);
      chk("pif_addr_ok", mmu_i_addr_ok, 0);
      tlb_v = 1'b1; csr_plv = 2'd3;
      #1;
      chk("ppi_flags", {mmu_i_tlbr, mmu_i_pif, mmu_i_ppi}, 3'b001);
      chk("ppi_mem_req", mem_req, 0);
      csr_plv = 2'd0; tlb_ppn = 20'h12345;
      #1;
      chk("tlb_flags", {mmu_i_tlbr, mmu_i_pif, mmu_i_ppi}, 3'b000);
      chk("tlb_mem_addr", mem_addr, 64'h1234_5ab8);
      chk("tlb_vaddr", tlb_vaddr, 64'h0040_0abc);
      chk("tlb_addr_ok", mmu_i_addr_ok, 1);
      step();
      mem_data_ok = 1'b1; mem_rdata = 64'hcafe_f00d_dead_beef;
      #1;
      chk("tlb_rdata", mmu_i_rdata, 64'h0000_0000_cafe_f00d);

      // fill with no returns: only DEPTH accepted
      csr_da = 1'b1;
      acc = 0;
      for (int i = 0; i < 6; i++) begin
         step();
         mmu_i_req = 1'b1; mmu_i_addr = 32'h1000_0000 + 32'(i * 4);
         #1;
         if (i >= 4) chk("full_block", mmu_i_addr_ok, 0);
         acc += int'(mmu_i_addr_ok);
      end
      chk("fill_cnt", acc, 4);

      // full: push allowed with a same-cycle pop
      step();
      mmu_i_req = 1'b1; mmu_i_addr = 32'h1000_0010;
      mem_data_ok = 1'b1; mem_rdata = 64'ha000_0000_b000_0000;
      #1;
      chk("full_pp_addr_ok", mmu_i_addr_ok, 1);
      chk("full_pp_rdata", mmu_i_rdata, 64'ha000_0000_b000_0000);
      // remaining order: sel 1,0,1,0
      for (int i = 1; i <= 4; i++) begin
         step();
         d = {32'ha000_0000 + 32'(i), 32'hb000_0000 + 32'(i)};
         mem_data_ok = 1'b1; mem_rdata = d;
         #1;
         chk("drain_ok", mmu_i_data_ok, 1);
         chk("drain_rdata", mmu_i_rdata,
             (i % 2 == 1) ? {32'h0, d[63:32]} : d);
      end
      step();
      mem_data_ok = 1'b1;
      #1;
      chk("empty_data_ok", mmu_i_data_ok, 0);

      // reset with two outstanding
      for (int i = 0; i < 2; i++) begin
         step();
         mmu_i_req = 1'b1; mmu_i_addr = 32'h2000_0000 + 32'(i * 4);
         #1;
         chk("pre_rst_ok", mmu_i_addr_ok, 1);
      end
      step();
      resetn = 1'b0; mmu_i_req = 1'b1; mem_data_ok = 1'b1;
      #1;
      chk("inrst_addr_ok", mmu_i_addr_ok, 0);
      chk("inrst_data_ok", mmu_i_data_ok, 0);
      step();
      resetn = 1'b1; mem_data_ok = 1'b1;
      #1;
      chk("postrst_data_ok", mmu_i_data_ok, 0);
      step();
      mmu_i_req = 1'b1; mmu_i_addr = 32'h3000_0004;
      #1;
      chk("postrst_addr_ok", mmu_i_addr_ok, 1);
      step();
      mem_data_ok = 1'b1; mem_rdata = 64'h5555_6666_7777_8888;
      #1;
      chk("postrst_data", {mmu_i_data_ok, mmu_i_rdata},
          {1'b1, 64'h0000_0000_5555_6666});

      step();
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
